// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-32 subset core with one shared, ready-handshaked instruction/data port.
// Optional: define MIPS_EXT_OPS_EN to add bne, ori and the R-type nor.
module mips_multicycle_core #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        dbg_reg_addr,
  output logic [31:0]       dbg_reg_data,
  output logic [31:0]       pc_out,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

`ifdef MIPS_EXT_OPS_EN
  localparam bit EXT_OPS = 1'b1;
`else
  localparam bit EXT_OPS = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ORI = 6'h0D, OP_LW  = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t           state, state_next;
  logic [31:0]      pc, ir, a, b, alu_out, mdr;
  logic [31:0]      rf [32];
  logic [CNT_W-1:0] cnt;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, imm_zext;
  logic [31:0] alu_r, imm_r;
  logic        branch_taken, retire, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign imm_zext = {16'h0000, ir[15:0]};

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
      FN_NOR:  return EXT_OPS;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    case (funct)
      FN_SUB:  alu_r = a - b;
      FN_AND:  alu_r = a & b;
      FN_OR:   alu_r = a | b;
      FN_NOR:  alu_r = ~(a | b);
      FN_SLT:  alu_r = {31'b0, $signed(a) < $signed(b)};
      default: alu_r = a + b;
    endcase
  end

  assign imm_r        = (EXT_OPS && opcode == OP_ORI) ? (a | imm_zext) : (a + imm_sext);
  assign branch_taken = (EXT_OPS && opcode == OP_BNE) ? (a != b) : (a == b);

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = funct_legal(funct) ? S_EXEC : S_HALT;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_ORI:       state_next = EXT_OPS ? S_ADDIEX : S_HALT;
          OP_BEQ:       state_next = S_BRANCH;
          OP_BNE:       state_next = EXT_OPS ? S_BRANCH : S_HALT;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_HALT;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_out;
    case (state)
      S_MEMWB:  begin rf_we = 1'b1; rf_wdata = mdr; end
      S_ALUWB:  begin rf_we = 1'b1; rf_waddr = rd; end
      S_ADDIWB: rf_we = 1'b1;
      default:  rf_we = 1'b0;
    endcase
  end

  // NOTE: the register file is cleared on reset too, so it is an array of flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      cnt     <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) begin
          ir <= mem_rdata;
          pc <= pc + 32'd4;
        end
        S_DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= pc + {imm_sext[29:0], 2'b00};
        end
        S_MEMADR: alu_out <= a + imm_sext;
        S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
        S_EXEC:   alu_out <= alu_r;
        S_ADDIEX: alu_out <= imm_r;
        S_BRANCH: if (branch_taken) pc <= alu_out;
        S_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
        default:  ;
      endcase
      if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  assign mem_req      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign mem_we       = (state == S_MEMWR);
  assign mem_addr     = (state == S_FETCH) ? pc[ADDR_W+1:2] : alu_out[ADDR_W+1:2];
  assign mem_wdata    = b;
  assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : rf[dbg_reg_addr];
  assign pc_out       = pc;
  assign halted       = (state == S_HALT);
  assign instr_count  = cnt;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed programs plus random programs checked against an ISA-level model.
`timescale 1ns/1ps
module tb_mips_multicycle_core;
  localparam int          AW  = 10;
  localparam logic [31:0] RPC = 32'h0000_0040;
`ifdef MIPS_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic          mem_req, mem_we, mem_ready = 1'b0, halted;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata = 32'd0, dbg_reg_data, pc_out, instr_count;
  logic [4:0]    dbg_reg_addr = 5'd0;

  mips_multicycle_core #(.ADDR_W(AW), .RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data), .pc_out(pc_out),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: fetches (words 16..511) wait wf cycles, data accesses wait wd cycles.
  logic [31:0]   mem [1024];
  int            wf = 0, wd = 0, wcnt = 0, lim = 0;
  bit            ovr_rdy = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [31:0]   hold_wdata;

  always @(negedge clk) begin
    if (ovr_rdy) begin
      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      wcnt      = 0;
    end else if (rst !== 1'b0 || mem_req !== 1'b1) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      wcnt      = 0;
    end else begin
      if (wcnt == 0) begin
        hold_addr  = mem_addr;
        hold_wdata = mem_wdata;
        lim = (!mem_we && mem_addr >= 10'd16 && mem_addr < 10'd512) ? wf : wd;
      end else begin
        check("addr_stable", 32'(mem_addr), 32'(hold_addr));
        if (mem_we) check("wdata_stable", mem_wdata, hold_wdata);
      end
      if (wcnt >= lim) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        wcnt = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end
  end

  // Architectural reference model: one call executes one instruction and reports its cycle cost.
  logic [31:0] m_mem [1024];
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_halt;

  function automatic logic [31:0] enc_r(int f, int s, int t, int d);
    return {6'd0, s[4:0], t[4:0], d[4:0], 5'd0, f[5:0]};
  endfunction
  function automatic logic [31:0] enc_i(int op, int s, int t, int imm);
    return {op[5:0], s[4:0], t[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] enc_j(int op, int tgt);
    return {op[5:0], tgt[25:0]};
  endfunction

  task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_rf[r] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_pc = RPC; m_cnt = 0; m_halt = 1'b0;
  endtask

  task automatic model_step(output int cyc);
    logic [31:0] ins, a, b, sx, ea;
    logic [4:0]  s, t, d;
    bit          ok;
    cyc = 0;
    if (m_halt) return;
    ins  = m_mem[m_pc[AW+1:2]];
    m_pc = m_pc + 32'd4;
    s = ins[25:21]; t = ins[20:16]; d = ins[15:11];
    a = m_rf[s]; b = m_rf[t];
    sx = {{16{ins[15]}}, ins[15:0]};
    ea = a + sx;
    ok = 1'b1;
    case (ins[31:26])
      6'h00: begin
        cyc = 4 + wf;
        case (ins[5:0])
          6'h20: m_wr(d, a + b);
          6'h22: m_wr(d, a - b);
          6'h24: m_wr(d, a & b);
          6'h25: m_wr(d, a | b);
          6'h2A: m_wr(d, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          6'h27: if (EXT) m_wr(d, ~(a | b)); else ok = 1'b0;
          default: ok = 1'b0;
        endcase
      end
      6'h23: begin m_wr(t, m_mem[ea[AW+1:2]]); cyc = 5 + wf + wd; end
      6'h2B: begin m_mem[ea[AW+1:2]] = b; cyc = 4 + wf + wd; end
      6'h04: begin if (a == b) m_pc = m_pc + (sx << 2); cyc = 3 + wf; end
      6'h05: if (EXT) begin if (a != b) m_pc = m_pc + (sx << 2); cyc = 3 + wf; end else ok = 1'b0;
      6'h08: begin m_wr(t, ea); cyc = 4 + wf; end
      6'h0D: if (EXT) begin m_wr(t, a | {16'd0, ins[15:0]}); cyc = 4 + wf; end else ok = 1'b0;
      6'h02: begin m_pc = {m_pc[31:28], ins[25:0], 2'b00}; cyc = 3 + wf; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin m_halt = 1'b1; cyc = 2 + wf; end
    else m_cnt++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) m_mem[i] = (i >= 512) ? $urandom : 32'd0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic prep();
    for (int i = 0; i < 1024; i++) mem[i] = m_mem[i];
    model_reset();
    do_reset();
  endtask

  task automatic read_reg(input int r, output logic [31:0] v);
    dbg_reg_addr = 5'(r);
    #0.1;
    v = dbg_reg_data;
  endtask

  task automatic compare_state(input string tag);
    logic [31:0] v;
    int diffs = 0;
    for (int r = 0; r < 32; r++) begin
      read_reg(r, v);
      check($sformatf("%s_r%0d", tag, r), v, m_rf[r]);
    end
    check({tag, "_pc"}, pc_out, m_pc);
    check({tag, "_count"}, instr_count, 32'(m_cnt));
    check({tag, "_halted"}, 32'(halted), 32'(m_halt));
    for (int i = 0; i < 1024; i++) if (mem[i] !== m_mem[i]) diffs++;
    check({tag, "_mem_diffs"}, 32'(diffs), 32'd0);
  endtask

  task automatic exec(input int n, input int cyc_fixed, input string tag);
    int total = 0, c;
    for (int i = 0; i < n; i++) begin model_step(c); total += c; end
    if (cyc_fixed > 0) total = cyc_fixed;
    repeat (total) @(posedge clk);
    #1;
    compare_state(tag);
  endtask

  task automatic gen_random(input int len);
    int fns [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
    int k, s, t, d, imm, off;
    clear_mem();
    for (int i = 0; i < len; i++) begin
      k = $urandom_range(0, 19);
      s = $urandom_range(0, 7); t = $urandom_range(0, 7); d = $urandom_range(0, 7);
      imm = $urandom_range(0, 65535);
      off = 32'h800 + 4 * $urandom_range(0, 255);
      if (k <= 6)       m_mem[16+i] = enc_r(fns[$urandom_range(0, 4)], s, t, d);
      else if (k <= 9)  m_mem[16+i] = enc_i(8, s, t, imm);
      else if (k <= 12) m_mem[16+i] = enc_i(32'h23, 0, t, off);
      else if (k <= 15) m_mem[16+i] = enc_i(32'h2B, 0, t, off);
      else if (k <= 17) m_mem[16+i] = enc_i(4, s, t, $urandom_range(0, 3));
      else if (k == 18) m_mem[16+i] = enc_j(2, 16 + $urandom_range(i + 1, len));
      else case ($urandom_range(0, 2))
        0:       m_mem[16+i] = enc_i(5, s, t, $urandom_range(0, 3));
        1:       m_mem[16+i] = enc_i(32'h0D, s, t, imm);
        default: m_mem[16+i] = enc_r(32'h27, s, t, d);
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d checks run, expected bench to finish", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int gap;

    // Reset state, then the ALU program with zero waits.
    wf = 0; wd = 0;
    clear_mem();
    m_mem[16] = enc_i(8, 0, 1, 5);
    m_mem[17] = enc_i(8, 0, 2, -3);
    m_mem[18] = enc_r(32'h20, 1, 2, 3);
    m_mem[19] = enc_r(32'h22, 2, 1, 4);
    m_mem[20] = enc_r(32'h2A, 2, 1, 5);
    prep();
    check("rst_pc", pc_out, 32'h40);
    check("rst_addr", 32'(mem_addr), 32'h10);
    check("rst_req", 32'(mem_req), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", instr_count, 32'd0);
    exec(5, 20, "alu");
    check("alu_count20", instr_count, 32'd5);
    read_reg(3, v); check("alu_r3", v, 32'd2);
    read_reg(4, v); check("alu_r4", v, 32'hFFFF_FFF8);
    read_reg(5, v); check("alu_r5", v, 32'd1);

    // Store then load with three wait cycles on each data access.
    wf = 0; wd = 3;
    clear_mem();
    m_mem[16] = enc_i(8, 0, 1, 5);
    m_mem[17] = enc_i(32'h2B, 0, 1, 8);
    m_mem[18] = enc_i(32'h23, 0, 6, 8);
    prep();
    for (int k = 0; k < 200 && instr_count != 32'd2; k++) begin @(posedge clk); #1; end
    check("sw_retired", instr_count, 32'd2);
    gap = 0;
    for (int k = 0; k < 200 && instr_count != 32'd3; k++) begin @(posedge clk); #1; gap++; end
    check("lw_cycles", 32'(gap), 32'd8);
    read_reg(6, v); check("lw_r6", v, 32'd5);
    for (int i = 0; i < 3; i++) model_step(gap);
    compare_state("memw");

    // Control flow: taken beq, $0 write discard, not-taken beq, jump.
    wf = 1; wd = 0;
    clear_mem();
    m_mem[16] = enc_i(8, 0, 1, 5);
    m_mem[17] = enc_i(4, 1, 1, 2);
    m_mem[18] = enc_i(8, 0, 2, 1);
    m_mem[19] = enc_i(8, 0, 2, 2);
    m_mem[20] = enc_r(32'h20, 1, 1, 0);
    m_mem[21] = enc_i(4, 1, 0, 5);
    m_mem[22] = enc_j(2, 32'h40);
    m_mem[64] = enc_i(8, 0, 3, 9);
    prep();
    exec(5, 0, "ctl");
    check("ctl_pc_jump", pc_out, 32'h100);
    read_reg(2, v); check("ctl_skip_r2", v, 32'd0);
    read_reg(0, v); check("ctl_r0", v, 32'd0);
    exec(1, 0, "ctl2");

    // Illegal opcode halts with the PC frozen past it.
    wf = 0; wd = 0;
    clear_mem();
    m_mem[16] = enc_i(8, 0, 1, 7);
    m_mem[17] = 32'hFC00_0000;
    prep();
    exec(2, 0, "ill");
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_req", 32'(mem_req), 32'd0);
      check("halt_pc", pc_out, 32'h48);
      check("halt_count", instr_count, 32'd1);
    end
    do_reset();
    check("unhalt_pc", pc_out, 32'h40);
    check("unhalt_req", 32'(mem_req), 32'd1);
    check("unhalt_halted", 32'(halted), 32'd0);

    // Reset during a load wait, with the memory completing in the reset cycle.
    wf = 0; wd = 3;
    clear_mem();
    m_mem[16]  = enc_i(32'h23, 0, 6, 32'h804);
    m_mem[513] = 32'h1234_5678;
    prep();
    repeat (3) @(posedge clk);
    #1;
    check("mrd_addr", 32'(mem_addr), 32'h201);
    @(posedge clk); #1;
    check("mrd_wait_addr", 32'(mem_addr), 32'h201);
    check("mrd_wait_we", 32'(mem_we), 32'd0);
    rst = 1'b1; ovr_rdy = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ovr_rdy = 1'b0;
    check("abort_pc", pc_out, 32'h40);
    check("abort_addr", 32'(mem_addr), 32'h10);
    check("abort_req", 32'(mem_req), 32'd1);
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_count", instr_count, 32'd0);
    read_reg(6, v); check("abort_r6", v, 32'd0);
    exec(1, 0, "rerun");

    // Random programs against the model.
    for (int t = 0; t < 8; t++) begin
      wf = $urandom_range(0, 2);
      wd = $urandom_range(0, 3);
      gen_random(24);
      prep();
      exec(20, 0, $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Multicycle MIPS-32 subset core. It is the parametrised successor of the single-cycle processor.
- One shared instruction/data memory port with a ready handshake, so wait-state memories are supported.
- FSM-sequenced datapath with internal 32x32 register file, retired-instruction counter and sticky halt on illegal opcodes.
- Sits at processor top level; memory and debug are external.

Parameters:
- ADDR_W, 10, word-address width of memory port; byte address bits [ADDR_W+1:2] are used.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_req  output  1  memory access request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  store data.
- mem_rdata  input  32  read data; sampled on the cycle mem_ready=1.
- mem_ready  input  1  access completes this cycle.
- dbg_reg_addr  input  5  debug register-file read index.
- dbg_reg_data  output  32  combinational register-file read; 0 when index is 0.
- pc_out  output  32  current PC.
- halted  output  1  sticky illegal-instruction flag.
- instr_count  output  CNT_W  retired-instruction count.

Behaviour:
- ISA: R-type add, sub, and, or, slt (op 0); lw 0x23; sw 0x2B; beq 0x04; addi 0x08; j 0x02.
- Any other opcode, or op 0 with any other funct, is illegal and enters HALT.
- Register $0 reads 0; writes to it are discarded.
- Reset (any state, including mid-access):
  - next edge sets pc=RESET_PC, state=FETCH, all 32 registers=0, IR=0, halted=0, instr_count=0.
  - mem_req=1, mem_we=0 and mem_addr=RESET_PC[ADDR_W+1:2] from the first post-reset cycle.
  - A pending memory access is abandoned.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are combinational from state and registers.
  - They stay stable until the cycle mem_ready=1.
  - The FSM advances only on that cycle; mem_ready is ignored when mem_req=0.
- FSM states and actions:
  - FETCH: mem_req, addr=pc. On ready: IR<=mem_rdata, pc<=pc+4, go to DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=pc+(sext(imm)<<2). Then dispatch by opcode: lw/sw/addi -> MEMADR/MEMADR/ADDIEX; R -> EXEC; beq -> BRANCH; j -> JUMP; illegal -> HALT.
  - MEMADR: ALUOut<=A+sext(imm). lw -> MEMRD; sw -> MEMWR.
  - MEMRD: read at ALUOut[ADDR_W+1:2]. On ready: MDR<=mem_rdata, go to MEMWB.
  - MEMWB: rf[rt]<=MDR, retire, go to FETCH.
  - MEMWR: write B at ALUOut[ADDR_W+1:2]. On ready: retire, go to FETCH.
  - EXEC: ALUOut<=A op B, then ALUWB.
  - ALUWB: rf[rd]<=ALUOut, retire, go to FETCH.
  - ADDIEX: ALUOut<=A+sext(imm), then ADDIWB.
  - ADDIWB: rf[rt]<=ALUOut, retire, go to FETCH.
  - BRANCH: if A==B then pc<=ALUOut; retire; go to FETCH.
  - JUMP: pc<={pc[31:28],IR[25:0],2'b00}; retire; go to FETCH.
  - HALT: halted=1, mem_req=0, PC frozen; exit only by rst.
- CPI with zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- Arithmetic: 32-bit, wrap-around with no overflow trap. slt is signed.
- Illegal instruction does not retire. PC wraps modulo 2^32; addresses are truncated to ADDR_W.
- instr_count increments by 1 on retire and wraps at 2^CNT_W.

Optional Feature:
- MIPS_EXT_OPS_EN defined adds three instructions:
  - bne (0x05): taken when A!=B, 3 cycles.
  - ori (0x0D): zero-extended immediate, ADDIEX/ADDIWB path.
  - R-type nor (funct 0x27).
- MIPS_EXT_OPS_EN undefined: those encodings are illegal and enter HALT.

Test Plan:
- Reset check: rst held 2 cycles with RESET_PC=0x40 -> pc_out=0x40, mem_addr=0x10, mem_req=1, halted=0, instr_count=0.
- ALU program, zero waits:
  - Program: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$2,$1; slt $5,$2,$1.
  - Expected registers: $3=2, $4=0xFFFFFFF8, $5=1.
  - Expected count and timing: instr_count=5 after 20 cycles.
- Memory with waits:
  - Program: sw $1,8($0) then lw $6,8($0).
  - Memory inserts 3 wait cycles per access.
  - Expected: $6=5, lw takes 8 cycles, and mem_addr/mem_wdata stay stable across the waits.
- Control flow: beq $1,$1,+2 skips 2 instructions; j to 0x100 -> pc_out=0x100; beq not taken -> pc+4. $0 stays 0 after add $0,$1,$1.
- Illegal opcode 0x3F:
  - Expected: halted=1, mem_req=0 and PC frozen for 10 cycles; instr_count is unchanged.
  - Then rst -> fetch resumes at RESET_PC.
- Reset mid-access: rst asserted during a MEMRD wait -> next cycle in FETCH at RESET_PC, no register write, and a late mem_ready is ignored.
